// File: rtl/alu_arbiter.sv
// Shares one ALU between the main datapath (port 0) and an auxiliary requester (port 1); latency: accept -> RspValid two cycles later.
// Backpressure: one operation in flight, requests stall until the response is taken; define ALU_ARB_RR_EN for round-robin arbitration (default fixed priority).
module alu_arbiter #(
    parameter int DATA_WIDTH     = 32,
    parameter int ALU_CTRL_WIDTH = 3
) (
    input  logic                      clk,
    input  logic                      reset,

    input  logic                      ReqValid_0,
    output logic                      ReqReady_0,
    input  logic [DATA_WIDTH-1:0]     ReqSrcA_0,
    input  logic [DATA_WIDTH-1:0]     ReqSrcB_0,
    input  logic [ALU_CTRL_WIDTH-1:0] ReqCtrl_0,
    output logic                      RspValid_0,
    input  logic                      RspReady_0,
    output logic [DATA_WIDTH-1:0]     RspResult_0,
    output logic                      RspZero_0,

    input  logic                      ReqValid_1,
    output logic                      ReqReady_1,
    input  logic [DATA_WIDTH-1:0]     ReqSrcA_1,
    input  logic [DATA_WIDTH-1:0]     ReqSrcB_1,
    input  logic [ALU_CTRL_WIDTH-1:0] ReqCtrl_1,
    output logic                      RspValid_1,
    input  logic                      RspReady_1,
    output logic [DATA_WIDTH-1:0]     RspResult_1,
    output logic                      RspZero_1,

    output logic [DATA_WIDTH-1:0]     SrcA,
    output logic [DATA_WIDTH-1:0]     SrcB,
    output logic [ALU_CTRL_WIDTH-1:0] ALUControl,
    input  logic [DATA_WIDTH-1:0]     ALUResult,
    input  logic                      Zero
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                    state_q, state_d;
    logic                      grant_q, grant_d;
    logic [DATA_WIDTH-1:0]     srca_q, srca_d;
    logic [DATA_WIDTH-1:0]     srcb_q, srcb_d;
    logic [ALU_CTRL_WIDTH-1:0] ctrl_q, ctrl_d;
    logic [DATA_WIDTH-1:0]     result_q, result_d;
    logic                      zero_q, zero_d;

    logic win_0, win_1;
    logic rsp_ready_g;

    assign rsp_ready_g = grant_q ? RspReady_1 : RspReady_0;

`ifdef ALU_ARB_RR_EN
    // Pointer names the port that wins a tie; it flips away from each served port.
    logic ptr_q, ptr_d;

    always_comb begin
        if (!ptr_q) begin
            win_0 = ReqValid_0;
            win_1 = ReqValid_1 & ~ReqValid_0;
        end else begin
            win_1 = ReqValid_1;
            win_0 = ReqValid_0 & ~ReqValid_1;
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (state_q == RESP && rsp_ready_g) begin
            ptr_d = ~grant_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`else
    assign win_0 = ReqValid_0;
    assign win_1 = ReqValid_1 & ~ReqValid_0;
`endif

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        srca_d     = srca_q;
        srcb_d     = srcb_q;
        ctrl_d     = ctrl_q;
        result_d   = result_q;
        zero_d     = zero_q;
        ReqReady_0 = 1'b0;
        ReqReady_1 = 1'b0;
        RspValid_0 = 1'b0;
        RspValid_1 = 1'b0;
        case (state_q)
            IDLE: begin
                ReqReady_0 = win_0;
                ReqReady_1 = win_1;
                if (win_0) begin
                    srca_d  = ReqSrcA_0;
                    srcb_d  = ReqSrcB_0;
                    ctrl_d  = ReqCtrl_0;
                    grant_d = 1'b0;
                    state_d = EXEC;
                end else if (win_1) begin
                    srca_d  = ReqSrcA_1;
                    srcb_d  = ReqSrcB_1;
                    ctrl_d  = ReqCtrl_1;
                    grant_d = 1'b1;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                result_d = ALUResult;
                zero_d   = Zero;
                state_d  = RESP;
            end
            RESP: begin
                RspValid_0 = ~grant_q;
                RspValid_1 = grant_q;
                if (rsp_ready_g) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            grant_q  <= 1'b0;
            srca_q   <= '0;
            srcb_q   <= '0;
            ctrl_q   <= '0;
            result_q <= '0;
            zero_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            srca_q   <= srca_d;
            srcb_q   <= srcb_d;
            ctrl_q   <= ctrl_d;
            result_q <= result_d;
            zero_q   <= zero_d;
        end
    end

    assign SrcA        = srca_q;
    assign SrcB        = srcb_q;
    assign ALUControl  = ctrl_q;
    assign RspResult_0 = result_q;
    assign RspResult_1 = result_q;
    assign RspZero_0   = zero_q;
    assign RspZero_1   = zero_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: behavioural ALU attached to the ALU port, directed scenarios plus a
// randomized run checked against a transaction-level model of the arbitration policy.
module tb_alu_arbiter;
    localparam int DW = 32;
    localparam int CW = 3;
`ifdef ALU_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    logic ReqValid_0, ReqReady_0, RspValid_0, RspReady_0, RspZero_0;
    logic ReqValid_1, ReqReady_1, RspValid_1, RspReady_1, RspZero_1;
    logic [DW-1:0] ReqSrcA_0, ReqSrcB_0, RspResult_0, ReqSrcA_1, ReqSrcB_1, RspResult_1;
    logic [CW-1:0] ReqCtrl_0, ReqCtrl_1, ALUControl;
    logic [DW-1:0] SrcA, SrcB, ALUResult;
    logic          Zero;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.DATA_WIDTH(DW), .ALU_CTRL_WIDTH(CW)) dut (
        .clk(clk), .reset(reset),
        .ReqValid_0(ReqValid_0), .ReqReady_0(ReqReady_0), .ReqSrcA_0(ReqSrcA_0),
        .ReqSrcB_0(ReqSrcB_0), .ReqCtrl_0(ReqCtrl_0), .RspValid_0(RspValid_0),
        .RspReady_0(RspReady_0), .RspResult_0(RspResult_0), .RspZero_0(RspZero_0),
        .ReqValid_1(ReqValid_1), .ReqReady_1(ReqReady_1), .ReqSrcA_1(ReqSrcA_1),
        .ReqSrcB_1(ReqSrcB_1), .ReqCtrl_1(ReqCtrl_1), .RspValid_1(RspValid_1),
        .RspReady_1(RspReady_1), .RspResult_1(RspResult_1), .RspZero_1(RspZero_1),
        .SrcA(SrcA), .SrcB(SrcB), .ALUControl(ALUControl),
        .ALUResult(ALUResult), .Zero(Zero)
    );

    // {zero, result} of the ALU's operation table
    function automatic logic [DW:0] alu_fn(input logic [CW-1:0] c, input logic [DW-1:0] a, input logic [DW-1:0] b);
        logic [DW-1:0] r;
        case (c)
            3'd0:    r = a & b;
            3'd1:    r = a | b;
            3'd2:    r = a + b;
            3'd4:    r = a - b;
            3'd5:    r = a * b;
            3'd6:    r = (a < b) ? 32'd1 : 32'd0;
            default: r = '0;
        endcase
        return {(r == '0), r};
    endfunction

    assign {Zero, ALUResult} = alu_fn(ALUControl, SrcA, SrcB);

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic settle;
        #3;
    endtask

    task automatic clear_inputs;
        ReqValid_0 = 0; ReqSrcA_0 = '0; ReqSrcB_0 = '0; ReqCtrl_0 = '0; RspReady_0 = 0;
        ReqValid_1 = 0; ReqSrcA_1 = '0; ReqSrcB_1 = '0; ReqCtrl_1 = '0; RspReady_1 = 0;
    endtask

    task automatic set_req(input int p, input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [CW-1:0] c);
        if (p == 0) begin
            ReqValid_0 = 1; ReqSrcA_0 = a; ReqSrcB_0 = b; ReqCtrl_0 = c;
        end else begin
            ReqValid_1 = 1; ReqSrcA_1 = a; ReqSrcB_1 = b; ReqCtrl_1 = c;
        end
    endtask

    // Drives one full transaction on port p and reports what was observed.
    task automatic run_op(input int p, input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [CW-1:0] c,
                          output logic [DW-1:0] r, output logic z, output int lat, output bit ok);
        int n;
        ok = 1; r = '0; z = 0; lat = -1; n = 0;
        set_req(p, a, b, c);
        settle;
        while (!(p == 0 ? ReqReady_0 : ReqReady_1) && n < 10) begin
            step; settle; n++;
        end
        if (!(p == 0 ? ReqReady_0 : ReqReady_1)) begin
            ok = 0; ReqValid_0 = 0; ReqValid_1 = 0; step;
            return;
        end
        step;
        ReqValid_0 = 0; ReqValid_1 = 0;
        lat = 1;
        settle;
        while (!(p == 0 ? RspValid_0 : RspValid_1) && lat < 10) begin
            step; settle; lat++;
        end
        if (!(p == 0 ? RspValid_0 : RspValid_1)) begin
            ok = 0; step;
            return;
        end
        r = (p == 0) ? RspResult_0 : RspResult_1;
        z = (p == 0) ? RspZero_0 : RspZero_1;
        if (p == 0) RspReady_0 = 1; else RspReady_1 = 1;
        step;
        RspReady_0 = 0; RspReady_1 = 0;
    endtask

    task automatic test_reset;
        clear_inputs;
        reset = 1;
        step; step;
        reset = 0;
        settle;
        n_checks++; if (SrcA !== '0 || SrcB !== '0 || ALUControl !== '0) begin n_fail++; $display("FAIL reset_alu_inputs: got %h %h %h want 0 0 0", SrcA, SrcB, ALUControl); end
        n_checks++; if (ReqReady_0 !== 0 || ReqReady_1 !== 0) begin n_fail++; $display("FAIL reset_req_ready: got %b%b want 00", ReqReady_0, ReqReady_1); end
        n_checks++; if (RspValid_0 !== 0 || RspValid_1 !== 0) begin n_fail++; $display("FAIL reset_rsp_valid: got %b%b want 00", RspValid_0, RspValid_1); end
        n_checks++; if (RspResult_0 !== '0 || RspZero_0 !== 0) begin n_fail++; $display("FAIL reset_result: got %h/%b want 0/0", RspResult_0, RspZero_0); end
        step;
    endtask

    task automatic test_add_port0;
        set_req(0, 32'd7, 32'd5, 3'd2);
        settle;
        n_checks++; if (ReqReady_0 !== 1 || ReqReady_1 !== 0) begin n_fail++; $display("FAIL add_req_ready: got %b%b want 10", ReqReady_0, ReqReady_1); end
        step;
        ReqValid_0 = 0;
        settle;
        n_checks++; if (RspValid_0 !== 0 || SrcA !== 32'd7 || SrcB !== 32'd5 || ALUControl !== 3'd2) begin n_fail++; $display("FAIL add_exec: got v=%b %h %h %h want 0 7 5 2", RspValid_0, SrcA, SrcB, ALUControl); end
        step; settle;
        n_checks++; if (RspValid_0 !== 1 || RspResult_0 !== 32'd12 || RspZero_0 !== 0) begin n_fail++; $display("FAIL add_rsp: got v=%b r=%0d z=%b want 1 12 0", RspValid_0, RspResult_0, RspZero_0); end
        RspReady_0 = 1;
        step;
        RspReady_0 = 0;
        settle;
        n_checks++; if (RspValid_0 !== 0) begin n_fail++; $display("FAIL add_rsp_done: got v=%b want 0", RspValid_0); end
        step;
    endtask

    task automatic test_stall_port1;
        set_req(1, 32'd9, 32'd9, 3'd4);
        settle;
        n_checks++; if (ReqReady_1 !== 1 || ReqReady_0 !== 0) begin n_fail++; $display("FAIL stall_accept: got rdy1=%b rdy0=%b want 1 0", ReqReady_1, ReqReady_0); end
        step;
        ReqValid_1 = 0;
        set_req(0, 32'd1, 32'd1, 3'd2);
        RspReady_0 = 1;
        settle;
        n_checks++; if (ReqReady_0 !== 0 || RspValid_1 !== 0) begin n_fail++; $display("FAIL stall_exec: got rdy0=%b v1=%b want 0 0", ReqReady_0, RspValid_1); end
        step;
        for (int k = 0; k < 4; k++) begin
            settle;
            n_checks++; if (RspValid_1 !== 1 || RspResult_1 !== '0 || RspZero_1 !== 1) begin n_fail++; $display("FAIL stall_hold%0d: got v=%b r=%h z=%b want 1 0 1", k, RspValid_1, RspResult_1, RspZero_1); end
            n_checks++; if (ReqReady_0 !== 0 || RspValid_0 !== 0) begin n_fail++; $display("FAIL stall_other%0d: got rdy0=%b v0=%b want 0 0", k, ReqReady_0, RspValid_0); end
            step;
        end
        ReqValid_0 = 0;
        RspReady_1 = 1;
        step;
        RspReady_1 = 0;
        ReqValid_0 = 1;
        settle;
        n_checks++; if (ReqReady_0 !== 1) begin n_fail++; $display("FAIL stall_release: got rdy0=%b want 1", ReqReady_0); end
        ReqValid_0 = 0;
        RspReady_0 = 0;
        step;
        ReqValid_1 = 1;
        settle;
        n_checks++; if (ReqReady_1 !== 1) begin n_fail++; $display("FAIL dropped_valid_idle: got rdy1=%b want 1", ReqReady_1); end
        ReqValid_1 = 0;
        step;
    endtask

    task automatic test_contention;
        int grants[$];
        int gcyc[$];
        int rsps = 0;
        int cyc = 0;
        int exp_g;
        clear_inputs;
        reset = 1; step; reset = 0;
        set_req(0, 32'hF0F0, 32'hFF00, 3'd0);
        set_req(1, 32'd3, 32'd4, 3'd5);
        RspReady_0 = 1; RspReady_1 = 1;
        while ((grants.size() < 4 || rsps < 4) && cyc < 60) begin
            settle;
            n_checks++; if (ReqReady_0 && ReqReady_1) begin n_fail++; $display("FAIL cont_both_ready: got 11 want one-hot at cycle %0d", cyc); end
            if (grants.size() < 4 && ReqReady_0) begin grants.push_back(0); gcyc.push_back(cyc); end
            else if (grants.size() < 4 && ReqReady_1) begin grants.push_back(1); gcyc.push_back(cyc); end
            if (RspValid_0 || RspValid_1) begin
                rsps++;
                n_checks++; if (cyc - gcyc[gcyc.size()-1] != 2) begin n_fail++; $display("FAIL cont_latency: got %0d want 2", cyc - gcyc[gcyc.size()-1]); end
                n_checks++; if ((RspValid_0 ? 0 : 1) != grants[grants.size()-1] || (RspValid_0 && RspValid_1)) begin n_fail++; $display("FAIL cont_rsp_port: got v=%b%b want port %0d", RspValid_1, RspValid_0, grants[grants.size()-1]); end
                if (RspValid_0) begin
                    n_checks++; if (RspResult_0 !== 32'hF000 || RspZero_0 !== 0) begin n_fail++; $display("FAIL cont_and: got %h/%b want f000/0", RspResult_0, RspZero_0); end
                end else begin
                    n_checks++; if (RspResult_1 !== 32'd12 || RspZero_1 !== 0) begin n_fail++; $display("FAIL cont_mul: got %0d/%b want 12/0", RspResult_1, RspZero_1); end
                end
            end
            step;
            cyc++;
        end
        clear_inputs;
        n_checks++; if (grants.size() != 4 || rsps != 4) begin n_fail++; $display("FAIL cont_count: got %0d grants %0d rsps want 4 4", grants.size(), rsps); end
        for (int k = 0; k < grants.size(); k++) begin
            exp_g = RR ? (k % 2) : 0;
            n_checks++; if (grants[k] != exp_g) begin n_fail++; $display("FAIL cont_grant%0d: got %0d want %0d", k, grants[k], exp_g); end
            if (k > 0) begin
                n_checks++; if (gcyc[k] - gcyc[k-1] != 3) begin n_fail++; $display("FAIL cont_occupancy%0d: got %0d want 3", k, gcyc[k] - gcyc[k-1]); end
            end
        end
        step;
    endtask

    task automatic test_slt;
        logic [DW-1:0] r; logic z; int lat; bit ok;
        run_op(0, 32'd2, 32'd3, 3'd6, r, z, lat, ok);
        n_checks++; if (!ok || lat != 2 || r !== 32'd1 || z !== 0) begin n_fail++; $display("FAIL slt_2_3: got ok=%0d lat=%0d r=%0d z=%b want 1 2 1 0", ok, lat, r, z); end
        run_op(0, 32'd3, 32'd2, 3'd6, r, z, lat, ok);
        n_checks++; if (!ok || lat != 2 || r !== 32'd0 || z !== 1) begin n_fail++; $display("FAIL slt_3_2: got ok=%0d lat=%0d r=%0d z=%b want 1 2 0 1", ok, lat, r, z); end
    endtask

    task automatic test_reset_mid;
        set_req(1, 32'h1, 32'h2, 3'd1);
        settle;
        n_checks++; if (ReqReady_1 !== 1) begin n_fail++; $display("FAIL rmid_accept: got %b want 1", ReqReady_1); end
        step;
        ReqValid_1 = 0;
        reset = 1;
        settle;
        step;
        reset = 0;
        settle;
        n_checks++; if (SrcA !== '0 || SrcB !== '0 || ALUControl !== '0) begin n_fail++; $display("FAIL rmid_alu_inputs: got %h %h %h want 0 0 0", SrcA, SrcB, ALUControl); end
        n_checks++; if (RspResult_1 !== '0 || RspZero_1 !== 0) begin n_fail++; $display("FAIL rmid_result: got %h/%b want 0/0", RspResult_1, RspZero_1); end
        for (int k = 0; k < 3; k++) begin
            n_checks++; if (RspValid_1 !== 0 || RspValid_0 !== 0) begin n_fail++; $display("FAIL rmid_no_rsp%0d: got %b%b want 00", k, RspValid_1, RspValid_0); end
            step; settle;
        end
        step;
        set_req(0, 32'd1, 32'd1, 3'd2);
        set_req(1, 32'd1, 32'd1, 3'd2);
        settle;
        n_checks++; if (ReqReady_0 !== 1 || ReqReady_1 !== 0) begin n_fail++; $display("FAIL rmid_first_grant: got %b%b want 10", ReqReady_0, ReqReady_1); end
        clear_inputs;
        step;
    endtask

    task automatic test_invalid_code;
        logic [DW-1:0] r; logic z; int lat; bit ok;
        run_op(0, 32'd5, 32'd6, 3'd3, r, z, lat, ok);
        n_checks++; if (!ok || lat != 2 || r !== '0 || z !== 1) begin n_fail++; $display("FAIL invalid_code: got ok=%0d lat=%0d r=%h z=%b want 1 2 0 1", ok, lat, r, z); end
    endtask

    task automatic test_random;
        bit pend[2];
        logic [DW-1:0] pa[2], pb[2];
        logic [CW-1:0] pc[2];
        logic [DW-1:0] cur_a, cur_b;
        logic [CW-1:0] cur_c;
        logic [DW:0] exp;
        bit busy = 0, in_resp = 0, ptr = 0;
        int g = 0, w, done = 0, cyc = 0;
        clear_inputs;
        reset = 1; step; reset = 0;
        pend[0] = 0; pend[1] = 0;
        cur_a = '0; cur_b = '0; cur_c = '0;
        while (done < 30 && cyc < 3000) begin
            for (int p = 0; p < 2; p++) begin
                if (!pend[p] && $urandom_range(0, 2) == 0) begin
                    pend[p] = 1;
                    pa[p] = $urandom_range(0, 1) ? $urandom : $urandom_range(0, 9);
                    pb[p] = ($urandom_range(0, 3) == 0) ? pa[p] : $urandom_range(0, 9);
                    pc[p] = 3'($urandom_range(0, 7));
                    set_req(p, pa[p], pb[p], pc[p]);
                end
            end
            ReqValid_0 = pend[0];
            ReqValid_1 = pend[1];
            RspReady_0 = 1'($urandom_range(0, 1));
            RspReady_1 = 1'($urandom_range(0, 1));
            settle;
            w = -1;
            if (!busy) begin
                if (RR) w = pend[ptr] ? int'(ptr) : (pend[!ptr] ? int'(!ptr) : -1);
                else    w = pend[0] ? 0 : (pend[1] ? 1 : -1);
            end
            n_checks++; if (ReqReady_0 !== (w == 0) || ReqReady_1 !== (w == 1)) begin n_fail++; $display("FAIL rand_ready cyc %0d: got %b%b want port %0d", cyc, ReqReady_1, ReqReady_0, w); end
            n_checks++; if (RspValid_0 !== (in_resp && g == 0) || RspValid_1 !== (in_resp && g == 1)) begin n_fail++; $display("FAIL rand_rsp_valid cyc %0d: got %b%b want port %0d", cyc, RspValid_1, RspValid_0, in_resp ? g : -1); end
            if (in_resp) begin
                exp = alu_fn(cur_c, cur_a, cur_b);
                n_checks++;
                if ((g == 0 ? RspResult_0 : RspResult_1) !== exp[DW-1:0] || (g == 0 ? RspZero_0 : RspZero_1) !== exp[DW]) begin
                    n_fail++; $display("FAIL rand_result cyc %0d op %0d %h,%h: got %h/%b want %h/%b", cyc, cur_c, cur_a, cur_b,
                                       g == 0 ? RspResult_0 : RspResult_1, g == 0 ? RspZero_0 : RspZero_1, exp[DW-1:0], exp[DW]);
                end
            end
            if (w >= 0) begin
                busy = 1; g = w; pend[w] = 0;
                cur_a = pa[w]; cur_b = pb[w]; cur_c = pc[w];
            end else if (busy && !in_resp) begin
                in_resp = 1;
            end else if (in_resp && (g == 0 ? RspReady_0 : RspReady_1)) begin
                busy = 0; in_resp = 0; ptr = (g == 0); done++;
            end
            step;
            cyc++;
        end
        n_checks++; if (done < 30) begin n_fail++; $display("FAIL rand_progress: got %0d completed want 30", done); end
        clear_inputs;
        RspReady_0 = 1; RspReady_1 = 1;
        step; step; step;
        clear_inputs;
    endtask

    initial begin
        reset = 1;
        clear_inputs;
        test_reset;
        test_add_port0;
        test_stall_port1;
        test_contention;
        test_slt;
        test_reset_mid;
        test_invalid_code;
        test_random;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
